ps2_key_decoder: RTL

- Keyboard front end of the pinball design. Receives raw PS/2 clock/data from the board pins and deframes 11-bit PS/2 frames.
- Decodes scan-code set 2 make/break/extended sequences and keeps a per-key "is pressed" vector for numpad keys 0-9.
- Feeds the game-control and flipper logic (key0/1/4/5/6 consumers) downstream and runs in the VGA pixel-clock domain.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_frame_rx.sv | 126 ++++++++++++
 rtl/ps2_key_decoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end.
// Holds the frame receiver state type, the scan-code set 2 prefix bytes and the
// numpad scan-code table used to maintain the key-held vector.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StCheck
  } rx_state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam int unsigned NUM_KEYS = 10;

  // Index i holds the make code of numpad key i.
  localparam logic [7:0] NUMPAD_SC [0:NUM_KEYS-1] = '{
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
  };

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver.
// Synchronizes the raw PS/2 clock/data pins, detects falling edges of the PS/2
// clock and deframes 11-bit frames (start, 8 data bits LSB first, parity, stop).
// Optional build macro: PS2_PARITY_CHECK_EN adds an odd-parity check to the
// stop-bit check; otherwise the parity bit is ignored.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   ps2_clk, ps2_dat    raw asynchronous PS/2 pins
//   byte_valid          one-cycle pulse, byte_data holds an accepted byte
//   byte_data           received data byte
//   frame_err           one-cycle pulse on bad start/stop/parity or timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  logic             clk_s1_q, clk_s2_q, clk_prev_q;
  logic             dat_s1_q, dat_s2_q;
  rx_state_e        state_q, state_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fall;
  logic dat;
  logic timeout_hit;
  logic frame_ok;

  assign fall = clk_prev_q & ~clk_s2_q;
  assign dat  = dat_s2_q;
  // An edge in the same cycle as the timeout wins.
  assign timeout_hit = (state_q == StRecv) && !fall &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat;
      dat_s2_q   <= dat_s1_q;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_q     <= stop_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    stop_d    = stop_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fall && !dat) begin
          state_d   = StRecv;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      StRecv: begin
        if (fall) begin
          cnt_d = '0;
          if (bit_cnt_q == 4'd9) begin
            stop_d  = dat;
            state_d = StCheck;
          end else begin
            // Right shift: after 9 bits data sits in [7:0] and parity in [8].
            shift_d   = {dat, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (timeout_hit) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StCheck: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = stop_q & (^shift_q);
`else
    frame_ok = stop_q;
`endif
    byte_valid = (state_q == StCheck) && frame_ok;
    frame_err  = ((state_q == StIdle) && fall && dat) || timeout_hit ||
                 ((state_q == StCheck) && !frame_ok);
  end

  assign byte_data = shift_q[7:0];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder top.
// Turns received bytes into scan-code set 2 events (handling F0 break and E0
// extended prefixes) and tracks which numpad keys 0-9 are currently held.
// Optional build macro: PS2_PARITY_CHECK_EN (enables parity check in the
// frame receiver).
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   ps2_clk, ps2_dat    raw asynchronous PS/2 pins
//   code_valid          one-cycle pulse per complete non-prefix scan code
//   code_byte           last scan-code byte, held between pulses
//   code_break          code was preceded by F0 (qualified by code_valid)
//   code_ext            code was preceded by E0 (qualified by code_valid)
//   keys_pressed        bit i set while numpad key i is held
//   frame_err           one-cycle pulse on any frame error
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       code_valid,
  output logic [7:0] code_byte,
  output logic       code_break,
  output logic       code_ext,
  output logic [9:0] keys_pressed,
  output logic       frame_err
);

  logic       rx_valid;
  logic [7:0] rx_byte;

  logic                break_pending_q, break_pending_d;
  logic                ext_pending_q, ext_pending_d;
  logic                code_valid_q, code_valid_d;
  logic [7:0]          code_byte_q, code_byte_d;
  logic                code_break_q, code_break_d;
  logic                code_ext_q, code_ext_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .byte_valid(rx_valid),
    .byte_data (rx_byte),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      break_pending_q <= 1'b0;
      ext_pending_q   <= 1'b0;
      code_valid_q    <= 1'b0;
      code_byte_q     <= '0;
      code_break_q    <= 1'b0;
      code_ext_q      <= 1'b0;
      keys_q          <= '0;
    end else begin
      break_pending_q <= break_pending_d;
      ext_pending_q   <= ext_pending_d;
      code_valid_q    <= code_valid_d;
      code_byte_q     <= code_byte_d;
      code_break_q    <= code_break_d;
      code_ext_q      <= code_ext_d;
      keys_q          <= keys_d;
    end
  end

  always_comb begin
    break_pending_d = break_pending_q;
    ext_pending_d   = ext_pending_q;
    code_valid_d    = 1'b0;
    code_byte_d     = code_byte_q;
    code_break_d    = code_break_q;
    code_ext_d      = code_ext_q;
    keys_d          = keys_q;
    if (rx_valid) begin
      if (rx_byte == SC_BREAK) begin
        break_pending_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_pending_d = 1'b1;
      end else begin
        code_valid_d    = 1'b1;
        code_byte_d     = rx_byte;
        code_break_d    = break_pending_q;
        code_ext_d      = ext_pending_q;
        break_pending_d = 1'b0;
        ext_pending_d   = 1'b0;
        // Extended codes share bytes with the numpad (E0 70 = Insert).
        if (!ext_pending_q) begin
          for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (rx_byte == NUMPAD_SC[i]) keys_d[i] = ~break_pending_q;
          end
        end
      end
    end
  end

  assign code_valid   = code_valid_q;
  assign code_byte    = code_byte_q;
  assign code_break   = code_break_q;
  assign code_ext     = code_ext_q;
  assign keys_pressed = keys_q;

endmodule
